prog_sequencer: RTL

- Top-level run controller for the PC/core.
- Owns the 2-bit per-instruction cycle Counter that the PC consumes, issues the PC Init pulse, and parks the core between programs.
- Accepts a Start request per program, detects the PC Halt pulse, and tracks the active program index across the three back-to-back programs.
- Provides a per-program watchdog so a hung program cannot lock up the bench.

---
 rtl/prog_sequencer_pkg.sv | 24 ++
 rtl/prog_sequencer_if.sv | 35 +++
 rtl/prog_sequencer_watchdog.sv | 37 +++
 rtl/prog_sequencer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/prog_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module  : prog_seq_pkg
// Brief   : Shared types and constants for the program sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package prog_seq_pkg;

  localparam int NUM_PROGS = 3;
  localparam int CNT_W     = 2;
  localparam int TIMEOUT   = 4096;
  localparam int TO_W      = 12;
  localparam int PARK_CNT  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_sequencer_if.sv
//------------------------------------------------------------------------------
// Module  : prog_sequencer_if
// Brief   : Control/status bundle between the sequencer and the PC/core side.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface prog_sequencer_if #(
  parameter int CNT_W = prog_seq_pkg::CNT_W
) ();

  logic             Start;
  logic             Stall;
  logic             Halt;
  logic [CNT_W-1:0] Counter;
  logic             Init;
  logic [1:0]       Prog_id;
  logic             Busy;
  logic             Done;
  logic             All_done;
  logic             Timeout;

  modport master (
    input  Start, Stall, Halt,
    output Counter, Init, Prog_id, Busy, Done, All_done, Timeout
  );

  modport slave (
    output Start, Stall, Halt,
    input  Counter, Init, Prog_id, Busy, Done, All_done, Timeout
  );

endinterface

`default_nettype wire

// File: rtl/prog_sequencer_watchdog.sv
//------------------------------------------------------------------------------
// Module  : prog_watchdog
// Brief   : Per-program RUN-cycle counter; flags the last allowed cycle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prog_watchdog #(
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 12
) (
  input  wire logic CLK,
  input  wire logic RST_N,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expired
);

  localparam logic [TO_W-1:0] c_last = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + TO_W'(1);
    end
  end

  assign expired = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/prog_sequencer.sv
//------------------------------------------------------------------------------
// Module  : prog_sequencer
// Brief   : Run controller: cycle counter, PC init pulse, program tracking.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prog_sequencer #(
  parameter int NUM_PROGS = prog_seq_pkg::NUM_PROGS,
  parameter int CNT_W     = prog_seq_pkg::CNT_W,
  parameter int TIMEOUT   = prog_seq_pkg::TIMEOUT,
  parameter int TO_W      = prog_seq_pkg::TO_W
) (
  input wire logic          CLK,
  input wire logic          RST_N,
  prog_sequencer_if.master  bus
);

  import prog_seq_pkg::*;

  localparam logic [CNT_W-1:0] c_park      = CNT_W'(PARK_CNT);
  localparam logic [1:0]       c_last_prog = 2'(NUM_PROGS - 1);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_counter;
  logic             r_init;
  logic [1:0]       r_prog_id;
  logic             r_busy;
  logic             r_done;
  logic             r_all_done;
  logic             r_timeout;

  logic w_wd_clear;
  logic w_wd_enable;
  logic w_wd_expired;

  assign w_wd_clear  = (r_state == IDLE) && bus.Start;
  assign w_wd_enable = (r_state == RUN);

  prog_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clear   (w_wd_clear),
    .enable  (w_wd_enable),
    .expired (w_wd_expired)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_counter  <= c_park;
      r_init     <= 1'b0;
      r_prog_id  <= 2'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_all_done <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_init <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_counter <= c_park;
          r_busy    <= 1'b0;
          if (bus.Start) begin
            r_timeout <= 1'b0;
            r_counter <= '0;
            r_busy    <= 1'b1;
            // A fresh batch re-initialises the PC; mid-batch programs continue from where it halted.
            if (r_prog_id == 2'd0 || r_all_done) begin
              r_state    <= INIT;
              r_init     <= 1'b1;
              r_all_done <= 1'b0;
              r_prog_id  <= 2'd0;
            end else begin
              r_state <= RUN;
            end
          end
        end
        INIT: begin
          r_state   <= RUN;
          r_counter <= '0;
          r_busy    <= 1'b1;
        end
        RUN: begin
          if (bus.Halt) begin
            r_state   <= IDLE;
            r_counter <= c_park;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            if (r_prog_id == c_last_prog) begin
              r_prog_id  <= 2'd0;
              r_all_done <= 1'b1;
            end else begin
              r_prog_id <= r_prog_id + 2'd1;
            end
          end else if (w_wd_expired) begin
            r_state   <= IDLE;
            r_counter <= c_park;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
          end else if (!bus.Stall) begin
            r_counter <= r_counter + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_counter <= c_park;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Counter  = r_counter;
  assign bus.Init     = r_init;
  assign bus.Prog_id  = r_prog_id;
  assign bus.Busy     = r_busy;
  assign bus.Done     = r_done;
  assign bus.All_done = r_all_done;
  assign bus.Timeout  = r_timeout;

endmodule

`default_nettype wire
